// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the time-of-day counter.
// The TWELVE_HOUR_EN build uses HOUR_MAX_12; the default build uses HOUR_MAX_24.
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX     = 8'h59;
  localparam bcd2_t MIN_MAX     = 8'h59;
  localparam bcd2_t HOUR_MAX_24 = 8'h23;
  localparam bcd2_t HOUR_MAX_12 = 8'h12;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WAIT_LOW
  } load_state_e;

  // Binary 0..99 to two-digit BCD, for elaboration-time constants.
  function automatic bcd2_t to_bcd(input int unsigned v);
    return bcd2_t'({4'((v / 10) % 10), 4'(v % 10)});
  endfunction

  // Both digits decimal and value within [lo, hi].
  // With valid digits, plain unsigned compare orders BCD correctly.
  function automatic logic bcd_in_range(input bcd2_t v, input bcd2_t lo, input bcd2_t hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v[3:0] == 4'd9) begin
      r = {4'(v[7:4] + 4'd1), 4'd0};
    end else begin
      r = {v[7:4], 4'(v[3:0] + 4'd1)};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN..MAX; wrap is asserted combinationally
// in the cycle it rolls over so fields can be chained in a single cycle.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX     = 8'h59,
  parameter bcd2_t MIN     = 8'h00,
  parameter bcd2_t RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       wrap
);

  bcd2_t value_q;
  bcd2_t value_d;

  // Load has priority over counting.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      value_d = (value_q == MAX) ? MIN : bcd_inc(value_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= RST_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign wrap  = en & ~load & (value_q == MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// BCD time of day advanced by synchronised Clk100 rising edges, with a
// one-shot time-set handshake. Define TWELVE_HOUR_EN for 12-hour mode with Pm.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HUND_MOD    = 100
) (
  input  logic       ClkIn,
  input  logic       Clr_,
  input  logic       Clk100,
  input  logic       Run,
  input  logic       LoadValid,
  input  logic [7:0] LoadHour,
  input  logic [7:0] LoadMin,
  input  logic [7:0] LoadSec,
`ifdef TWELVE_HOUR_EN
  input  logic       LoadPm,
  output logic       Pm,
`endif
  output logic       LoadReady,
  output logic       LoadErr,
  output logic [7:0] Hund,
  output logic [7:0] Sec,
  output logic [7:0] Min,
  output logic [7:0] Hour,
  output logic       SecTick,
  output logic       MinTick
);

  localparam bcd2_t HUND_TOP = to_bcd(HUND_MOD - 1);
`ifdef TWELVE_HOUR_EN
  localparam bcd2_t HOUR_LO  = 8'h01;
  localparam bcd2_t HOUR_HI  = HOUR_MAX_12;
  localparam bcd2_t HOUR_RST = HOUR_MAX_12;
`else
  localparam bcd2_t HOUR_LO  = 8'h00;
  localparam bcd2_t HOUR_HI  = HOUR_MAX_24;
  localparam bcd2_t HOUR_RST = 8'h00;
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;
  load_state_e            state_q, state_d;
  logic                   load_ready_q, load_ready_d;
  logic                   load_err_q, load_err_d;
  logic                   sec_tick_q, sec_tick_d;
  logic                   min_tick_q, min_tick_d;

  logic load_ok_c;
  logic load_wr_c;
  logic count_en_c;
  logic hund_wrap, sec_wrap, min_wrap, hour_wrap_unused;

  // Synchroniser, edge detect, and a registered tick: S+1 cycles to the counters.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], Clk100};
    prev_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  assign load_ok_c = bcd_in_range(LoadHour, HOUR_LO, HOUR_HI)
                   & bcd_in_range(LoadMin, 8'h00, MIN_MAX)
                   & bcd_in_range(LoadSec, 8'h00, SEC_MAX);

  // An accepted write wins over a coincident tick, which is then dropped.
  assign load_wr_c  = (state_q == ACCEPT) & load_ok_c;
  assign count_en_c = tick_q & Run & ~load_wr_c;

  always_comb begin
    state_d      = state_q;
    load_ready_d = 1'b0;
    load_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (LoadValid) state_d = ACCEPT;
      end
      ACCEPT: begin
        state_d      = WAIT_LOW;
        load_ready_d = load_ok_c;
        load_err_d   = ~load_ok_c;
      end
      WAIT_LOW: begin
        if (!LoadValid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sec_tick_d = hund_wrap;
  assign min_tick_d = sec_wrap;

  always_ff @(posedge ClkIn or posedge Clr_) begin
    if (Clr_) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      tick_q       <= 1'b0;
      state_q      <= IDLE;
      load_ready_q <= 1'b0;
      load_err_q   <= 1'b0;
      sec_tick_q   <= 1'b0;
      min_tick_q   <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      tick_q       <= tick_d;
      state_q      <= state_d;
      load_ready_q <= load_ready_d;
      load_err_q   <= load_err_d;
      sec_tick_q   <= sec_tick_d;
      min_tick_q   <= min_tick_d;
    end
  end

  bcd_mod_counter #(.MAX(HUND_TOP), .MIN(8'h00), .RST_VAL(8'h00)) u_hund (
    .clk(ClkIn), .rst(Clr_), .en(count_en_c), .load(load_wr_c),
    .load_val(8'h00), .value(Hund), .wrap(hund_wrap)
  );

  bcd_mod_counter #(.MAX(SEC_MAX), .MIN(8'h00), .RST_VAL(8'h00)) u_sec (
    .clk(ClkIn), .rst(Clr_), .en(hund_wrap), .load(load_wr_c),
    .load_val(LoadSec), .value(Sec), .wrap(sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX), .MIN(8'h00), .RST_VAL(8'h00)) u_min (
    .clk(ClkIn), .rst(Clr_), .en(sec_wrap), .load(load_wr_c),
    .load_val(LoadMin), .value(Min), .wrap(min_wrap)
  );

  // In 12-hour mode the hour field runs 12, 01..11; it never carries further.
  bcd_mod_counter #(.MAX(HOUR_HI), .MIN(HOUR_LO), .RST_VAL(HOUR_RST)) u_hour (
    .clk(ClkIn), .rst(Clr_), .en(min_wrap), .load(load_wr_c),
    .load_val(LoadHour), .value(Hour), .wrap(hour_wrap_unused)
  );

`ifdef TWELVE_HOUR_EN
  logic pm_q, pm_d;

  // Meridiem flips on the 11 -> 12 step.
  always_comb begin
    pm_d = pm_q;
    if (load_wr_c) begin
      pm_d = LoadPm;
    end else if (min_wrap && (Hour == 8'h11)) begin
      pm_d = ~pm_q;
    end
  end

  always_ff @(posedge ClkIn or posedge Clr_) begin
    if (Clr_) begin
      pm_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
    end
  end

  assign Pm = pm_q;
`endif

  assign LoadReady = load_ready_q;
  assign LoadErr   = load_err_q;
  assign SecTick   = sec_tick_q;
  assign MinTick   = min_tick_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Randomised bench for time_of_day_counter against a decimal time-of-day model.
`timescale 1ns/1ps
module tb_time_of_day_counter;

  localparam int unsigned S  = 2;
  localparam int unsigned HM = 100;
`ifdef TWELVE_HOUR_EN
  localparam int HLO = 1;
  localparam int HHI = 12;
  localparam logic [7:0] HRST = 8'h12;
`else
  localparam int HLO = 0;
  localparam int HHI = 23;
  localparam logic [7:0] HRST = 8'h00;
`endif

  logic       ClkIn = 1'b0;
  logic       Clr_;
  logic       Clk100;
  logic       Run;
  logic       LoadValid;
  logic [7:0] LoadHour, LoadMin, LoadSec;
  logic       LoadReady, LoadErr, SecTick, MinTick;
  logic [7:0] Hund, Sec, Min, Hour;
`ifdef TWELVE_HOUR_EN
  logic       LoadPm, Pm;
`endif

  always #10 ClkIn = ~ClkIn;

  time_of_day_counter #(.SYNC_STAGES(S), .HUND_MOD(HM)) dut (
    .ClkIn(ClkIn), .Clr_(Clr_), .Clk100(Clk100), .Run(Run), .LoadValid(LoadValid),
    .LoadHour(LoadHour), .LoadMin(LoadMin), .LoadSec(LoadSec),
`ifdef TWELVE_HOUR_EN
    .LoadPm(LoadPm), .Pm(Pm),
`endif
    .LoadReady(LoadReady), .LoadErr(LoadErr), .Hund(Hund), .Sec(Sec), .Min(Min),
    .Hour(Hour), .SecTick(SecTick), .MinTick(MinTick)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: time held as plain decimal integers.
  int m_hu, m_s, m_mi, m_h;
  bit m_pm;
  int phase;
  bit last_c;
  logic [S:0] pipe;
  bit e_ready, e_err, e_st, e_mt;
  int cnt_ready, cnt_err, cnt_st, cnt_both;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int dec(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hu = 0; m_s = 0; m_mi = 0; m_h = (HLO == 1) ? 12 : 0; m_pm = 0;
    phase = 0; last_c = 0; pipe = '0;
    e_ready = 0; e_err = 0; e_st = 0; e_mt = 0;
  endtask

  task automatic next_hour();
    if (HLO == 1) begin
      if (m_h == 11) begin m_h = 12; m_pm = !m_pm; end
      else if (m_h == 12) m_h = 1;
      else m_h++;
    end else begin
      m_h = (m_h + 1) % 24;
    end
  endtask

  task automatic advance();
    m_hu++;
    if (m_hu == HM) begin
      m_hu = 0; e_st = 1; m_s++;
      if (m_s == 60) begin
        m_s = 0; e_mt = 1; m_mi++;
        if (m_mi == 60) begin m_mi = 0; next_hour(); end
      end
    end
  endtask

  // Effect of one ClkIn rising edge on the model.
  task automatic model_clock();
    bit rise, tick, ok;
    int lh, lm, ls;
    rise = Clk100 && !last_c;
    last_c = Clk100;
    tick = pipe[S];
    pipe = {pipe[S-1:0], rise};
    e_ready = 0; e_err = 0; e_st = 0; e_mt = 0;
    lh = dec(LoadHour); lm = dec(LoadMin); ls = dec(LoadSec);
    ok = (lh >= HLO) && (lh <= HHI) && (lm >= 0) && (lm <= 59) && (ls >= 0) && (ls <= 59);
    if (phase == 1 && ok) begin
      m_h = lh; m_mi = lm; m_s = ls; m_hu = 0; e_ready = 1;
`ifdef TWELVE_HOUR_EN
      m_pm = LoadPm;
`endif
    end else begin
      if (phase == 1) e_err = 1;
      if (tick && Run) advance();
    end
    case (phase)
      0: if (LoadValid) phase = 1;
      1: phase = 2;
      default: if (!LoadValid) phase = 0;
    endcase
  endtask

  task automatic compare_all();
    chk("hund", Hund, bcd(m_hu));
    chk("sec", Sec, bcd(m_s));
    chk("min", Min, bcd(m_mi));
    chk("hour", Hour, bcd(m_h));
    chk("load_ready", 8'(LoadReady), 8'(e_ready));
    chk("load_err", 8'(LoadErr), 8'(e_err));
    chk("sec_tick", 8'(SecTick), 8'(e_st));
    chk("min_tick", 8'(MinTick), 8'(e_mt));
`ifdef TWELVE_HOUR_EN
    chk("pm", 8'(Pm), 8'(m_pm));
`endif
    if (LoadReady === 1'b1) cnt_ready++;
    if (LoadErr === 1'b1) cnt_err++;
    if (SecTick === 1'b1) cnt_st++;
    if (SecTick === 1'b1 && MinTick === 1'b1) cnt_both++;
  endtask

  task automatic step();
    @(posedge ClkIn);
    if (!Clr_) model_clock();
    @(negedge ClkIn);
    compare_all();
  endtask

  task automatic edges(input int n);
    for (int k = 0; k < n; k++) begin
      Clk100 = 1'b1;
      repeat ($urandom_range(2, 5)) step();
      Clk100 = 1'b0;
      repeat ($urandom_range(2, 5)) step();
    end
  endtask

  task automatic load_txn(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input bit pm, input int hold);
    LoadHour = h; LoadMin = m; LoadSec = s;
`ifdef TWELVE_HOUR_EN
    LoadPm = pm;
`endif
    LoadValid = 1'b1;
    repeat (hold) step();
    LoadValid = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hund"}, Hund, 8'h00);
    chk({tag, "_sec"}, Sec, 8'h00);
    chk({tag, "_min"}, Min, 8'h00);
    chk({tag, "_hour"}, Hour, HRST);
    chk({tag, "_ready"}, 8'(LoadReady), 8'h00);
    chk({tag, "_err"}, 8'(LoadErr), 8'h00);
    chk({tag, "_ticks"}, 8'({SecTick, MinTick}), 8'h00);
  endtask

  task automatic do_clear(input string tag);
    #2 Clr_ = 1'b1;
    #1 check_reset_outputs(tag);
    model_reset();
    repeat (2) step();
    Clr_ = 1'b0;
  endtask

  task automatic rnd_load();
    logic [7:0] h, m, s;
    h = ($urandom_range(0, 3) == 0) ? 8'($urandom) : bcd($urandom_range(HLO, HHI));
    m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : bcd($urandom_range(0, 59));
    s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : bcd($urandom_range(0, 59));
    load_txn(h, m, s, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
  endtask

  initial begin
    int r;
    Clr_ = 1'b1; Clk100 = 1'b0; Run = 1'b1; LoadValid = 1'b0;
    LoadHour = 8'h00; LoadMin = 8'h00; LoadSec = 8'h00;
`ifdef TWELVE_HOUR_EN
    LoadPm = 1'b0;
`endif
    model_reset();
    #5 check_reset_outputs("reset");
    @(negedge ClkIn);
    Clr_ = 1'b0;

    // One second of edges from reset.
    cnt_st = 0;
    edges(100);
    repeat (S + 3) step();
    chk("sec1_hund", Hund, 8'h00);
    chk("sec1_sec", Sec, 8'h01);
    chk("sec1_sectick_count", 8'(cnt_st), 8'd1);

    // Full rollover at end of day / 11:59:59.99 AM.
`ifdef TWELVE_HOUR_EN
    load_txn(8'h11, 8'h59, 8'h59, 1'b0, 2);
`else
    load_txn(8'h23, 8'h59, 8'h59, 1'b0, 2);
`endif
    edges(99);
    repeat (S + 3) step();
    chk("roll_hund99", Hund, 8'h99);
    cnt_both = 0;
    edges(1);
    repeat (S + 3) step();
    chk("roll_hund", Hund, 8'h00);
    chk("roll_sec", Sec, 8'h00);
    chk("roll_min", Min, 8'h00);
`ifdef TWELVE_HOUR_EN
    chk("roll_hour", Hour, 8'h12);
    chk("roll_pm", 8'(Pm), 8'h01);
`else
    chk("roll_hour", Hour, 8'h00);
`endif
    chk("roll_both_ticks", 8'(cnt_both), 8'd1);

    // Held LoadValid yields one transaction.
    cnt_ready = 0;
    load_txn(8'h12, 8'h34, 8'h56, 1'b0, 20);
    chk("hold_ready_count", 8'(cnt_ready), 8'd1);
    chk("hold_time", Hour, 8'h12);
    chk("hold_min", Min, 8'h34);
    chk("hold_sec", Sec, 8'h56);
    chk("hold_hund", Hund, 8'h00);
    load_txn(8'h01, 8'h02, 8'h03, 1'b0, 2);
    chk("reassert_ready_count", 8'(cnt_ready), 8'd2);

    // Rejected loads leave time untouched.
    cnt_err = 0;
    load_txn(8'h01, 8'h60, 8'h00, 1'b0, 3);
    load_txn(8'h1A, 8'h00, 8'h00, 1'b0, 3);
    chk("err_count", 8'(cnt_err), 8'd2);
    chk("err_min", Min, 8'h02);
    chk("err_hund", Hund, 8'h00);
    edges(3);
    repeat (S + 3) step();
    chk("err_counting", Hund, 8'h03);

    // Tick landing on the accepting write is dropped.
    LoadHour = 8'h07; LoadMin = 8'h08; LoadSec = 8'h09;
    Clk100 = 1'b1;
    repeat (S) step();
    LoadValid = 1'b1;
    step();
    step();
    chk("coinc_hund", Hund, 8'h00);
    chk("coinc_sec", Sec, 8'h09);
    chk("coinc_hour", Hour, 8'h07);
    chk("coinc_sectick", 8'(SecTick), 8'h00);
    LoadValid = 1'b0; Clk100 = 1'b0;
    repeat (4) step();
    chk("coinc_after", Hund, 8'h00);

    // Run low freezes time.
    Run = 1'b0;
    edges(50);
    repeat (S + 3) step();
    chk("frozen_hund", Hund, 8'h00);
    chk("frozen_sec", Sec, 8'h09);
    chk("frozen_min", Min, 8'h08);
    Run = 1'b1;

    // Clear during WAIT_LOW, then a still-high LoadValid restarts.
    LoadHour = 8'h10; LoadMin = 8'h20; LoadSec = 8'h30; LoadValid = 1'b1;
    repeat (3) step();
    do_clear("clr_wait");
    cnt_ready = 0;
    repeat (3) step();
    chk("clr_restart_ready", 8'(cnt_ready), 8'd1);
    LoadValid = 1'b0;
    repeat (3) step();

    // Clear while counting.
    edges(7);
    Clk100 = 1'b1;
    step();
    do_clear("clr_count");
    Clk100 = 1'b0;
    repeat (4) step();

    // Randomised mix of edges, Run changes, loads and clears.
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 75) begin
        Run = ($urandom_range(0, 9) != 0);
        edges(1);
      end else if (r < 97) begin
        rnd_load();
      end else begin
        Clk100 = 1'($urandom_range(0, 1));
        step();
        do_clear("clr_rand");
      end
    end
    repeat (S + 3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
